// File: rtl/ifetch_align.sv
// Aligns 16/32-bit instructions out of 64-bit I-SRAM lines, stitching line-straddling instructions.
// Latency: combinational from the returning line to rv32_instr; a straddle costs one extra line read.
// Backpressure: hold freezes every flop and replays the last outputs; flush discards partial state.
module ifetch_align #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter bit          RVC_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        cpurst_n,
    input  logic [31:0] pc,
    input  logic        isram_cs_ff,
    input  logic [28:0] isram_adr_ff,
    input  logic [63:0] isram_rdata,
    input  logic        flush,
    input  logic        hold,
    output logic [31:0] rv32_instr,
    output logic        isrv16,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    output logic        split_pend,
    output logic        misalign_err
);

    typedef enum logic [1:0] {EMPTY, LINE, SPLIT} state_t;

    state_t      state_q;
    logic [63:0] line_q;
    logic [28:0] line_adr_q;
    logic        line_vld_q;
    logic [15:0] half_q;

    logic [31:0] snap_instr_q;
    logic        snap_rv16_q;
    logic        snap_vld_q;
    logic        snap_split_q;

    logic [63:0] src;
    logic [28:0] src_adr;
    logic [28:0] next_adr;
    logic        avail;
    logic        hit;
    logic        split_hit;
    logic        misalign;
    logic [15:0] h;
    logic [15:0] h_hi;
    logic        long_at_end;
    logic        straddle;
    logic [31:0] raw_instr;
    logic        raw_vld;
    logic        comb_rv16;
    logic [31:0] comb_instr;
    logic        comb_split;
    logic        use_snap;

    assign src       = isram_cs_ff ? isram_rdata  : line_q;
    assign src_adr   = isram_cs_ff ? isram_adr_ff : line_adr_q;
    assign avail     = isram_cs_ff | line_vld_q;
    assign hit       = avail & (src_adr == pc[31:3]);
    assign next_adr  = pc[31:3] + 29'd1;
    assign split_hit = avail & (src_adr == next_adr);
    assign misalign  = pc[0] | (pc[1] & ~RVC_EN);

    always_comb begin
        h    = src[15:0];
        h_hi = src[31:16];
        case (pc[2:1])
            2'd0: begin h = src[15:0];  h_hi = src[31:16]; end
            2'd1: begin h = src[31:16]; h_hi = src[47:32]; end
            2'd2: begin h = src[47:32]; h_hi = src[63:48]; end
            default: begin h = src[63:48]; h_hi = 16'h0000; end
        endcase
    end

    // A 32-bit instruction starting in the last halfword needs the next line's first halfword.
    assign long_at_end = (pc[2:1] == 2'b11) & (h[1:0] == 2'b11);
    assign straddle    = (state_q != SPLIT) & hit & long_at_end & ~misalign & ~flush;

    always_comb begin
        raw_instr = NOP_INSTR;
        raw_vld   = 1'b0;
        if (!flush && !misalign) begin
            if (state_q == SPLIT) begin
                if (split_hit) begin
                    raw_instr = {src[15:0], half_q};
                    raw_vld   = 1'b1;
                end
            end else if (hit && !long_at_end) begin
                raw_instr = {h_hi, h};
                raw_vld   = 1'b1;
            end
        end
    end

    assign comb_rv16  = RVC_EN & raw_vld & (raw_instr[1:0] != 2'b11);
    assign comb_instr = comb_rv16 ? {16'h0000, raw_instr[15:0]} : raw_instr;
    assign comb_split = ~flush & (straddle |
                                  ((state_q == SPLIT) & ~(split_hit & ~misalign)));

    // During a stall the mini-decode must see exactly what it saw on the last free cycle.
    assign use_snap     = hold & ~flush;
    assign rv32_instr   = use_snap ? snap_instr_q : comb_instr;
    assign isrv16       = use_snap ? snap_rv16_q  : comb_rv16;
    assign instr_valid  = use_snap ? snap_vld_q   : raw_vld;
    assign split_pend   = use_snap ? snap_split_q : comb_split;
    assign instr_pc     = pc;
    assign misalign_err = misalign;

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state_q      <= EMPTY;
            line_q       <= '0;
            line_adr_q   <= '0;
            line_vld_q   <= 1'b0;
            half_q       <= '0;
            snap_instr_q <= NOP_INSTR;
            snap_rv16_q  <= 1'b0;
            snap_vld_q   <= 1'b0;
            snap_split_q <= 1'b0;
        end else if (flush) begin
            state_q      <= EMPTY;
            line_vld_q   <= 1'b0;
            half_q       <= '0;
            snap_instr_q <= comb_instr;
            snap_rv16_q  <= comb_rv16;
            snap_vld_q   <= raw_vld;
            snap_split_q <= comb_split;
        end else if (!hold) begin
            snap_instr_q <= comb_instr;
            snap_rv16_q  <= comb_rv16;
            snap_vld_q   <= raw_vld;
            snap_split_q <= comb_split;
            if (isram_cs_ff) begin
                line_q     <= isram_rdata;
                line_adr_q <= isram_adr_ff;
                line_vld_q <= 1'b1;
            end
            if (!misalign) begin
                case (state_q)
                    EMPTY, LINE: begin
                        if (straddle) begin
                            half_q  <= h;
                            state_q <= SPLIT;
                        end else if (avail) begin
                            state_q <= LINE;
                        end
                    end
                    SPLIT: begin
                        if (split_hit) state_q <= LINE;
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

endmodule
